// File: rtl/inst_table_pkg.sv
// Shared types and sizing for the instance descriptor table.
// Command opcodes, descriptor/transform payloads and the background default live here.
package inst_table_pkg;

    localparam int unsigned MAX_INST    = 256;
    localparam int unsigned MAX_VERT    = 8192;
    localparam int unsigned MAX_TRI     = 8192;
    localparam int unsigned MAX_TRI_CNT = 256;
    localparam int unsigned ID_W        = 8;

    localparam int unsigned VA_W   = $clog2(MAX_VERT);
    localparam int unsigned TA_W   = $clog2(MAX_TRI);
    localparam int unsigned TIDX_W = $clog2(MAX_TRI_CNT);

    // 3x4 fixed-point affine matrix, row-major
    localparam int unsigned XF_ROWS   = 3;
    localparam int unsigned XF_COLS   = 4;
    localparam int unsigned XF_ELEM_W = 16;

    typedef enum logic [2:0] {
        CLEAR     = 3'd0,
        SET_DESC  = 3'd1,
        SET_XFORM = 3'd2,
        SET_BG    = 3'd3,
        DONE      = 3'd4
    } inst_cmd_e;

    typedef struct packed {
        logic [VA_W-1:0]   vert_base;
        logic [TA_W-1:0]   tri_base;
        logic [TIDX_W-1:0] tri_count;
    } inst_desc_t;

    typedef struct packed {
        logic [XF_ROWS-1:0][XF_COLS-1:0][XF_ELEM_W-1:0] m;
    } transform_t;

    typedef logic [11:0] color12_t;

    localparam color12_t BG_DEFAULT = 12'hFFF;

    // True when an instance ID addresses an existing slot
    function automatic logic id_in_range(input logic [ID_W-1:0] id);
        return 32'(id) < MAX_INST;
    endfunction

endpackage

// File: rtl/inst_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// rclr loads zero into the read register instead of memory contents.
module inst_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic                     rclr,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-edge write to raddr is not visible here: read-first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rclr ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/instance_table.sv
// Per-instance scene descriptor table between the SPI command decoder and frame_driver.
// Commands update descriptor/transform RAMs; frame_driver captures entries with one-cycle latency.
module instance_table
    import inst_table_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  inst_cmd_e           cmd_op,
    input  logic [ID_W-1:0]     cmd_id,
    input  inst_desc_t          cmd_desc,
    input  transform_t          cmd_xform,
    input  color12_t            cmd_bg,
    output logic                cmd_err,
    input  logic [ID_W-1:0]     inst_id_rd,
    input  logic                capture_inst,
    output logic [VA_W-1:0]     curr_vert_base,
    output logic [TA_W-1:0]     curr_tri_base,
    output logic [TIDX_W-1:0]   curr_tri_count,
    output transform_t          transform_out,
    output logic [2*ID_W-1:0]   id_data,
    output logic [ID_W-1:0]     max_inst,
    output logic                create_done,
    output logic                busy
);

    localparam int unsigned SW_W   = $clog2(MAX_INST);
    localparam int unsigned ID2_W  = 2 * ID_W;
    localparam int unsigned DESC_W = $bits(inst_desc_t);
    localparam int unsigned XF_W   = $bits(transform_t);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [SW_W-1:0] sweep_q, sweep_d;
    color12_t        bg_q, bg_d;
    logic            cmd_ready_d, busy_d, cmd_err_d, create_done_d;
    logic [ID_W-1:0] max_inst_d;

    logic            accept;
    logic            wr_id_ok;
    logic            rd_id_ok;
    logic            desc_we, xf_we;
    logic [SW_W-1:0] wr_addr;
    inst_desc_t      desc_wdata, desc_rd;
    transform_t      xf_wdata;

    assign accept   = cmd_valid && cmd_ready;
    assign wr_id_ok = id_in_range(cmd_id);
    assign rd_id_ok = id_in_range(inst_id_rd);

    // Next-state, command decode and RAM write muxing
    always_comb begin
        state_d       = state_q;
        sweep_d       = sweep_q;
        bg_d          = bg_q;
        create_done_d = create_done;
        max_inst_d    = max_inst;
        cmd_err_d     = 1'b0;
        desc_we       = 1'b0;
        xf_we         = 1'b0;
        wr_addr       = SW_W'(cmd_id);
        desc_wdata    = cmd_desc;
        xf_wdata      = cmd_xform;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        CLEAR: begin
                            create_done_d = 1'b0;
                            max_inst_d    = '0;
                            bg_d          = BG_DEFAULT;
                            sweep_d       = '0;
                            state_d       = SWEEP;
                        end
                        SET_DESC: begin
                            // Zero count would underflow frame_driver's count-1 walk
                            if (!wr_id_ok || create_done || (cmd_desc.tri_count == '0)) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                desc_we = 1'b1;
                                if ((cmd_id != '0) && (cmd_id > max_inst)) begin
                                    max_inst_d = cmd_id;
                                end
                            end
                        end
                        SET_XFORM: begin
                            if (!wr_id_ok || create_done) begin
                                cmd_err_d = 1'b1;
                            end else begin
                                xf_we = 1'b1;
                            end
                        end
                        SET_BG: begin
                            bg_d = cmd_bg;
                        end
                        DONE: begin
                            create_done_d = 1'b1;
                        end
                        default: begin
                            cmd_err_d = 1'b1;
                        end
                    endcase
                end
            end
            SWEEP: begin
                desc_we    = 1'b1;
                xf_we      = 1'b1;
                wr_addr    = sweep_q;
                desc_wdata = '0;
                xf_wdata   = '0;
                sweep_d    = sweep_q + SW_W'(1);
                if (sweep_q == SW_W'(MAX_INST - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d == SWEEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sweep_q     <= '0;
            bg_q        <= BG_DEFAULT;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
            create_done <= 1'b0;
            max_inst    <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            bg_q        <= bg_d;
            cmd_ready   <= cmd_ready_d;
            busy        <= busy_d;
            cmd_err     <= cmd_err_d;
            create_done <= create_done_d;
            max_inst    <= max_inst_d;
        end
    end

    // Instance 0 reports the background colour; others echo their ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_data <= '0;
        end else if (capture_inst) begin
            if (!rd_id_ok) begin
                id_data <= '0;
            end else if (inst_id_rd == '0) begin
                id_data <= ID2_W'(bg_q);
            end else begin
                id_data <= ID2_W'(inst_id_rd);
            end
        end
    end

    inst_ram #(
        .WIDTH (DESC_W),
        .DEPTH (MAX_INST)
    ) u_desc_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (desc_we),
        .waddr (wr_addr),
        .wdata (desc_wdata),
        .re    (capture_inst),
        .rclr  (!rd_id_ok),
        .raddr (SW_W'(inst_id_rd)),
        .rdata (desc_rd)
    );

    inst_ram #(
        .WIDTH (XF_W),
        .DEPTH (MAX_INST)
    ) u_xf_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (xf_we),
        .waddr (wr_addr),
        .wdata (xf_wdata),
        .re    (capture_inst),
        .rclr  (!rd_id_ok),
        .raddr (SW_W'(inst_id_rd)),
        .rdata (transform_out)
    );

    assign curr_vert_base = desc_rd.vert_base;
    assign curr_tri_base  = desc_rd.tri_base;
    assign curr_tri_count = desc_rd.tri_count;

endmodule

// File: doc/instance_table.md
Name: instance_table

Overview:
- Holds per-instance scene descriptors written by the SPI command decoder.
- Descriptor fields: vertex base, triangle base, triangle count, transform.
- Instance 0 is reserved for the camera transform and background colour.
- Serves the frame driver's descriptor reads (inst_id_rd / capture_inst) with fixed one-cycle latency, and publishes max_inst and create_done to it.
- Sits directly upstream of frame_driver, between the SPI command path and the frame feed.

Parameters:
- MAX_INST, 256, number of instance slots (IDs 0..MAX_INST-1).
- MAX_VERT, 8192, vertex RAM depth (sets vertex base width VA_W = $clog2(MAX_VERT)).
- MAX_TRI, 8192, triangle RAM depth (sets triangle base width TA_W = $clog2(MAX_TRI)).
- MAX_TRI_CNT, 256, max triangles per instance (TIDX_W = $clog2(MAX_TRI_CNT)).
- ID_W, 8, instance ID width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  inst_cmd_e  CLEAR, SET_DESC, SET_XFORM, SET_BG, DONE.
- cmd_id  in  ID_W  target instance.
- cmd_desc  in  inst_desc_t  {vert_base[VA_W], tri_base[TA_W], tri_count[TIDX_W]}.
- cmd_xform  in  transform_t  transform payload.
- cmd_bg  in  color12_t  background colour payload.
- cmd_err  out  1  one-cycle pulse when an accepted command is rejected.
- inst_id_rd  in  ID_W  read address from frame_driver.
- capture_inst  in  1  read strobe from frame_driver.
- curr_vert_base  out  VA_W  vertex base of the captured instance.
- curr_tri_base  out  TA_W  triangle base of the captured instance.
- curr_tri_count  out  TIDX_W  triangle count of the captured instance.
- transform_out  out  transform_t  transform of the captured instance.
- id_data  out  2*ID_W  instance 0: {4'h0, bg colour}; otherwise {8'h00, id}.
- max_inst  out  8  highest instance ID written with SET_DESC since the last CLEAR.
- create_done  out  1  scene loaded; level signal.
- busy  out  1  high during the CLEAR sweep.

Behaviour:
- Reset values:
  - All outputs 0, except cmd_ready = 1.
  - bg register = 12'hFFF, so id_data = 16'h0FFF when instance 0 is captured after reset.
  - FSM in IDLE.
  - RAM contents are not reset.
- FSM states: IDLE, SWEEP.
- IDLE:
  - cmd_ready = 1. Accepted commands act at the accepting edge.
  - SET_DESC: writes the descriptor RAM; max_inst <= max(max_inst, cmd_id) when cmd_id != 0.
  - SET_XFORM: writes the transform RAM.
  - SET_BG: writes the bg register.
  - DONE: create_done <= 1.
  - CLEAR: create_done <= 0, max_inst <= 0, bg <= 12'hFFF, sweep counter <= 0, go to SWEEP.
- SWEEP:
  - cmd_ready = 0, busy = 1.
  - Writes zero to descriptor RAM and transform RAM at the sweep counter, one entry per cycle.
  - After writing entry MAX_INST-1, returns to IDLE. Total duration is exactly MAX_INST cycles.
- Rejections (command consumed, nothing written, cmd_err pulses for one cycle):
  - cmd_id >= MAX_INST.
  - SET_DESC with tri_count == 0; this prevents frame_driver count-1 underflow.
  - SET_DESC or SET_XFORM while create_done = 1; the scene is locked until CLEAR.
- Read port:
  - capture_inst sampled high at edge N: curr_*, transform_out and id_data present entry inst_id_rd from edge N+1.
  - Outputs hold until the next capture.
  - Reads are served in every state, including SWEEP.
- Write/read collision on the same ID in the same cycle: read-first, so the capture returns the old contents.
- inst_id_rd >= MAX_INST: outputs are all zero.
- Reset mid-SWEEP: FSM returns to IDLE; RAM is left partially cleared; create_done = 0.

Decomposition:
- inst_table_pkg holds:
  - inst_cmd_e: 3-bit enum, CLEAR=0, SET_DESC=1, SET_XFORM=2, SET_BG=3, DONE=4.
  - inst_desc_t packed struct.
  - constant BG_DEFAULT = 12'hFFF.
- One sub-module, inst_ram: parameterised width/depth simple dual-port RAM with registered, read-first read port.
  - Instantiated twice: descriptor RAM and transform RAM.

Test Plan:
- Reset, then capture_inst with id 0 -> next cycle id_data = 16'h0FFF, max_inst = 0, create_done = 0.
- SET_DESC id 3 {vb = 100, tb = 40, cnt = 12}, SET_XFORM id 3, DONE, then capture id 3 -> next cycle curr_vert_base = 100, curr_tri_base = 40, curr_tri_count = 12, transform matches, max_inst = 3, create_done = 1.
- SET_DESC id 5 with cnt = 0 -> cmd_err pulses once, max_inst unchanged, a capture of id 5 returns the prior contents.
- SET_DESC to id 2 and capture of id 2 in the same cycle -> old values appear; the next capture shows the new values.
- CLEAR after a loaded scene -> cmd_ready low and busy high for exactly 256 cycles, then a capture of id 3 returns zeros, and max_inst = 0, create_done = 0.
- Assert rst at cycle 50 of a sweep -> busy = 0 and cmd_ready = 1 immediately, FSM in IDLE.
